gpio_in_filter: RTL

//  Per-pin input conditioning between the GPIO pad ring's gpio_in bus and the GPIO register block.

---
 rtl/gpio_in_filter_if.sv | 26 ++
 rtl/gpio_in_filter.sv | 104 ++++++++++
 2 files changed

// File: rtl/gpio_in_filter_if.sv
// Register-side bundle for gpio_in_filter: pad input, per-pin config strobes and conditioned outputs.
// The slave modport is the filter itself; the master modport is the register block / pad ring side.
interface gpio_in_filter_if #(
  parameter int unsigned GPIO_WIDTH = 16,
  parameter int unsigned FILT_W     = 8
);
  logic [GPIO_WIDTH-1:0]   pad_in;
  logic [GPIO_WIDTH-1:0]   r_filt_en;
  logic [FILT_W-1:0]       r_filt_len;
  logic [GPIO_WIDTH-1:0]   r_int_en;
  logic [2*GPIO_WIDTH-1:0] r_int_mode;
  logic [GPIO_WIDTH-1:0]   r_int_clr;
  logic [GPIO_WIDTH-1:0]   gpio_in;
  logic [GPIO_WIDTH-1:0]   int_status;
  logic                    gpio_irq;

  modport master (
    output pad_in, r_filt_en, r_filt_len, r_int_en, r_int_mode, r_int_clr,
    input  gpio_in, int_status, gpio_irq
  );

  modport slave (
    input  pad_in, r_filt_en, r_filt_len, r_int_en, r_int_mode, r_int_clr,
    output gpio_in, int_status, gpio_irq
  );
endinterface

// File: rtl/gpio_in_filter.sv
// Per-pin GPIO input conditioning: synchroniser, optional debounce filter, edge/level event
// detection into sticky status, and a single registered IRQ line.
module gpio_in_filter #(
  parameter int unsigned GPIO_WIDTH  = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_W      = 8
) (
  input logic             clk,
  input logic             rst_n,
  gpio_in_filter_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_RISE  = 2'b00,
    MODE_FALL  = 2'b01,
    MODE_BOTH  = 2'b10,
    MODE_LEVEL = 2'b11
  } int_mode_e;

  logic [GPIO_WIDTH-1:0] w_filt;
  logic [GPIO_WIDTH-1:0] w_status;
  logic                  r_irq;

  genvar g;
  generate
    for (g = 0; g < GPIO_WIDTH; g++) begin : g_pin
      logic [SYNC_STAGES-1:0] r_sync;
      logic [FILT_W-1:0]      r_cnt;
      logic [FILT_W:0]        w_cnt_inc;
      logic                   w_sync;
      logic                   w_bypass;
      logic                   r_filt;
      logic                   r_prev;
      logic                   r_status;
      logic                   w_evt;
      int_mode_e              w_mode;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_sync <= '0;
        else        r_sync <= {r_sync[SYNC_STAGES-2:0], bus.pad_in[g]};
      end

      assign w_sync    = r_sync[SYNC_STAGES-1];
      assign w_bypass  = !bus.r_filt_en[g] || (bus.r_filt_len == '0);
      assign w_cnt_inc = {1'b0, r_cnt} + (FILT_W+1)'(1);

      // Compare against the live length so a shrunk r_filt_len releases a pending edge at once.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_filt <= 1'b0;
          r_cnt  <= '0;
        end else if (w_bypass) begin
          r_filt <= w_sync;
          r_cnt  <= '0;
        end else if (w_sync == r_filt) begin
          r_cnt  <= '0;
        end else if (w_cnt_inc >= {1'b0, bus.r_filt_len}) begin
          r_filt <= w_sync;
          r_cnt  <= '0;
        end else if (r_cnt != '1) begin
          r_cnt  <= w_cnt_inc[FILT_W-1:0];
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_prev <= 1'b0;
        else        r_prev <= r_filt;
      end

      assign w_mode = int_mode_e'(bus.r_int_mode[2*g +: 2]);

      always_comb begin
        w_evt = 1'b0;
        case (w_mode)
          MODE_RISE:  w_evt = r_filt & ~r_prev;
          MODE_FALL:  w_evt = ~r_filt & r_prev;
          MODE_BOTH:  w_evt = r_filt ^ r_prev;
          MODE_LEVEL: w_evt = r_filt;
          default:    w_evt = 1'b0;
        endcase
      end

      // Set has priority over the W1C strobe so an event coinciding with a clear is kept.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     r_status <= 1'b0;
        else if (w_evt) r_status <= 1'b1;
        else if (bus.r_int_clr[g]) r_status <= 1'b0;
      end

      assign w_filt[g]   = r_filt;
      assign w_status[g] = r_status;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_irq <= 1'b0;
    else        r_irq <= |(w_status & bus.r_int_en);
  end

  assign bus.gpio_in    = w_filt;
  assign bus.int_status = w_status;
  assign bus.gpio_irq   = r_irq;

endmodule
